instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  Clock; all state changes on its rising edge.
REQ-003 rst  input  1  Synchronous active-high reset; restores the default program image.
REQ-004 pc  input  16  Word address of the instruction to fetch.
REQ-005 ins  output  16  Instruction word at pc; combinational read.
REQ-006 oob  output  1  High when pc >= 256 (beyond storage).
REQ-007 we  input  1  Program-load write enable.
REQ-008 waddr  input  8  Program-load word address.
REQ-009 wdata  input  16  Program-load data word.
REQ-010 Parameter DEPTH, default 256: number of 16-bit words stored.

Function
REQ-011 Storage SHALL be DEPTH words of 16 bits, word-addressed (address n = nth instruction, no byte addressing).
REQ-012 ins SHALL equal mem[pc] combinationally, with no clock latency, whenever pc < DEPTH.
REQ-013 When pc >= DEPTH: ins = 0x0000 (NOP) and oob = 1; otherwise oob = 0; no wrap-around of pc.
REQ-014 Default image: addr 0x00..0x0B = 0x8A01, 0x8B02, 0x0C98, 0x2D03, 0x4E10, 0x6A05, 0xA00B, 0xC0F0, 0x1111, 0x2222, 0x7C21, 0xE000.
REQ-015 All other default addresses SHALL be 0x0000.
REQ-016 The default image SHALL be present at time zero, before any reset.
REQ-017 On a rising clk edge with rst=0 and we=1, mem[waddr] SHALL take wdata.
REQ-018 ins SHALL reflect a written word from the edge of the write onward when pc == waddr.
REQ-019 Writes SHALL affect only the addressed word.
REQ-020 we=0 SHALL leave contents unchanged.
REQ-021 Simultaneous rst=1 and we=1: reset wins; the write is discarded.
REQ-022 Changing pc SHALL never modify contents.
REQ-023 The read path SHALL be purely combinational, free of latches, and settle within the same delta or cycle as pc.

Reset
REQ-024 On a rising clk edge with rst=1, every word SHALL reload to the REQ-014/REQ-015 default image.
REQ-025 After the reset edge, ins SHALL immediately show the default word at the current pc.
REQ-026 oob SHALL depend only on pc and SHALL be unaffected by reset.
REQ-027 Reset asserted for multiple cycles SHALL be idempotent.

Verification
REQ-028 No reset, we=0, pc = 0, 1, 10, 11 in turn, 100 ns apart -> ins = 0x8A01, 0x8B02, 0x7C21, 0xE000.
REQ-029 pc = 0x0005 -> ins = 0x6A05, oob = 0; pc = 0x0100 -> ins = 0x0000, oob = 1; pc = 0xFFFF -> ins = 0x0000, oob = 1.
REQ-030 we=1, waddr=0x20, wdata=0xBEEF, one edge, then pc = 0x20 -> ins = 0xBEEF; pc = 0x21 -> ins = 0x0000.
REQ-031 Overwrite addr 0x01 with 0x5555, then rst=1 for one edge, pc = 1 -> ins = 0x8B02.
REQ-032 rst=1 and we=1 (waddr=0x02, wdata=0xAAAA) on the same edge, then pc = 2 -> ins = 0x0C98.
REQ-033 pc = 0x0B, then write 0x1234 to addr 0x0B -> ins changes from 0xE000 to 0x1234 at that edge, with no extra cycle.

Source files
------------

// File: rtl/instruction_memory_if.sv
// rtl/instruction_memory_if.sv - fetch and program-load bus of the instruction memory
//
// Signals
//   pc     16  word address of the instruction to fetch
//   ins    16  instruction word at pc (combinational)
//   oob     1  pc lies beyond the stored words
//   we      1  program-load write enable
//   waddr   8  program-load word address
//   wdata  16  program-load data word
//
// Modports
//   master  drives pc and the load port, receives ins/oob
//   slave   the memory side
interface instruction_memory_if;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        oob;
    logic        we;
    logic [7:0]  waddr;
    logic [15:0] wdata;

    modport master (
        output pc,
        output we,
        output waddr,
        output wdata,
        input  ins,
        input  oob
    );

    modport slave (
        input  pc,
        input  we,
        input  waddr,
        input  wdata,
        output ins,
        output oob
    );
endinterface

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction store with combinational fetch
//
// Parameters
//   DEPTH  number of 16-bit words stored (default 256)
//
// Ports
//   clk  in   clock; all state changes on its rising edge
//   rst  in   synchronous active-high reset; reloads the default program image
//   bus  slave modport of instruction_memory_if (pc/ins/oob fetch, we/waddr/wdata load)
module instruction_memory #(
    parameter int DEPTH = 256
) (
    input logic                  clk,
    input logic                  rst,
    instruction_memory_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [15:0] image_t [DEPTH];

    // Boot program; every word not listed is a NOP (0x0000).
    localparam image_t DEFAULT_IMAGE = '{
        0:  16'h8A01,
        1:  16'h8B02,
        2:  16'h0C98,
        3:  16'h2D03,
        4:  16'h4E10,
        5:  16'h6A05,
        6:  16'hA00B,
        7:  16'hC0F0,
        8:  16'h1111,
        9:  16'h2222,
        10: 16'h7C21,
        11: 16'hE000,
        default: 16'h0000
    };

    // The declaration value gives the boot program at power-up, so a
    // fetch is meaningful before the first reset ever arrives.
    logic [15:0] mem [DEPTH] = DEFAULT_IMAGE;

    logic          pc_in_range;
    logic          waddr_in_range;
    logic [AW-1:0] ridx;
    logic [AW-1:0] widx;

    assign pc_in_range    = int'(bus.pc) < DEPTH;
    assign waddr_in_range = int'(bus.waddr) < DEPTH;
    assign ridx           = AW'(bus.pc);
    assign widx           = AW'(bus.waddr);

    // Reset takes priority over a load on the same edge; a load to an
    // address outside the store is dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= DEFAULT_IMAGE;
        end else if (bus.we && waddr_in_range) begin
            mem[widx] <= bus.wdata;
        end
    end

    // Fetch is purely combinational: a word written on an edge is visible
    // at pc from that edge onward. pc never wraps; out-of-range fetches
    // return a NOP and flag oob, independent of reset.
    always_comb begin
        bus.ins = 16'h0000;
        bus.oob = 1'b1;
        if (pc_in_range) begin
            bus.ins = mem[ridx];
            bus.oob = 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - scoreboard bench for instruction_memory
module tb_instruction_memory;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instruction_memory_if bus ();

    instruction_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic        oob;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain array of 256 words plus the boot table.
    int unsigned ref_mem [256];
    int unsigned boot [12] = '{16'h8A01, 16'h8B02, 16'h0C98, 16'h2D03, 16'h4E10, 16'h6A05,
                               16'hA00B, 16'hC0F0, 16'h1111, 16'h2222, 16'h7C21, 16'hE000};

    function automatic void model_reload();
        for (int i = 0; i < 256; i++) ref_mem[i] = (i < 12) ? boot[i] : 0;
    endfunction

    function automatic void push_exp(input logic [15:0] p, input string nm);
        exp_t e;
        if (p < 256) begin
            e.ins = ref_mem[p][15:0];
            e.oob = 1'b0;
        end else begin
            e.ins = 16'h0000;
            e.oob = 1'b1;
        end
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    // One cycle: drive at negedge, expect the read before the edge, apply
    // the model's write/reset at the edge, expect the read after it.
    task automatic apply(input bit r, input bit w, input logic [7:0] wa,
                         input logic [15:0] wd, input logic [15:0] p, input string nm);
        @(negedge clk);
        rst       = r;
        bus.we    = w;
        bus.waddr = wa;
        bus.wdata = wd;
        bus.pc    = p;
        push_exp(p, {nm, "/pre"});
        @(posedge clk);
        if (r) model_reload();
        else if (w) ref_mem[wa] = {16'h0000, wd};
        push_exp(p, {nm, "/post"});
    endtask

    // Monitor: the read path is combinational, so the DUT presents a
    // result every half cycle; sample 1 ns after each clock edge.
    initial begin
        forever begin
            @(clk);
            #1;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.ins !== e.ins || bus.oob !== e.oob) begin
                    n_bad++;
                    $display("FAIL %s: got ins=%h oob=%b, expected ins=%h oob=%b",
                             e.name, bus.ins, bus.oob, e.ins, e.oob);
                end
            end
        end
    end

    initial begin
        logic [15:0] p;
        logic [7:0]  wa;
        bit          r;
        bit          w;

        bus.we    = 1'b0;
        bus.waddr = 8'h00;
        bus.wdata = 16'h0000;
        bus.pc    = 16'h0000;
        model_reload();

        // Power-up image, no reset applied yet.
        apply(0, 0, 8'h00, 16'h0000, 16'h0000, "boot_pc0");
        apply(0, 0, 8'h00, 16'h0000, 16'h0001, "boot_pc1");
        apply(0, 0, 8'h00, 16'h0000, 16'h000A, "boot_pc10");
        apply(0, 0, 8'h00, 16'h0000, 16'h000B, "boot_pc11");
        apply(0, 0, 8'h00, 16'h0000, 16'h0005, "pc5");
        apply(0, 0, 8'h00, 16'h0000, 16'h00FF, "pc_last");
        apply(0, 0, 8'h00, 16'h0000, 16'h0100, "oob_256");
        apply(0, 0, 8'h00, 16'h0000, 16'hFFFF, "oob_ffff");

        // Load a word, read it and its neighbour.
        apply(0, 1, 8'h20, 16'hBEEF, 16'h0020, "load_20");
        apply(0, 0, 8'h00, 16'h0000, 16'h0021, "neighbour_21");
        apply(0, 0, 8'h00, 16'h0000, 16'h0020, "readback_20");

        // Overwrite then reset restores the boot word.
        apply(0, 1, 8'h01, 16'h5555, 16'h0001, "overwrite_1");
        apply(1, 0, 8'h00, 16'h0000, 16'h0001, "reset_1");
        apply(0, 0, 8'h00, 16'h0000, 16'h0020, "reset_cleared_20");

        // Reset beats a simultaneous write; repeated reset is harmless.
        apply(1, 1, 8'h02, 16'hAAAA, 16'h0002, "rst_and_we");
        apply(1, 1, 8'h03, 16'h1357, 16'h0003, "rst_again");
        apply(0, 0, 8'h00, 16'h0000, 16'h0002, "after_rst_2");

        // Write at the current pc shows on that edge; oob ignores reset.
        apply(0, 1, 8'h0B, 16'h1234, 16'h000B, "write_at_pc");
        apply(1, 0, 8'h00, 16'h0000, 16'h0100, "oob_during_rst");

        // Randomized traffic concentrated on a small window so reads hit writes.
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 24) == 0);
            w  = ($urandom_range(0, 1) == 1);
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0:       p = 16'($urandom);
                1:       p = 16'($urandom_range(250, 270));
                2:       p = {8'h00, wa};
                default: p = 16'($urandom_range(0, 15));
            endcase
            apply(r, w, wa, 16'($urandom), p, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        bus.we = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
